uart_tx_periph: RTL and testbench

//  Memory-mapped UART transmitter; the responder to the CPU's peripheral data bus (rd/wr/addr/wdata/rdata).
//  The CPU writes bytes into an 8-deep TX FIFO. A serializer shifts them out on UART_TX as 8N1 frames.

---
 rtl/uart_tx_periph.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_periph.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
`default_nettype none
// ============================================================================
// uart_tx_periph : memory-mapped 8N1 UART transmitter, 8-deep TX FIFO, done IRQ
// Revision 1.0
// ============================================================================
module uart_tx_periph #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        UART_TX,
  output logic        irqout
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BCNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [7:0]        ADDR_TXD  = 8'h18;
  localparam logic [7:0]        ADDR_CON  = 8'h20;
  localparam logic [3:0]        DEPTH_CNT = 4'(FIFO_DEPTH);
  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state, state_nxt;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [3:0]         cnt;
  logic [7:0]         shift;
  logic [BCNT_W-1:0]  bit_cnt;
  logic [2:0]         bit_idx;
  logic               tx_line;
  logic               irq_en, tx_done, ovf;

  logic push, push_ok, pop, frame_end, con_wr;
  logic empty, full, busy, bit_last;
  logic unused_bits;

  assign push      = wr && (addr[7:0] == ADDR_TXD);
  assign con_wr    = wr && (addr[7:0] == ADDR_CON);
  assign empty     = (cnt == 4'd0);
  assign full      = (cnt == DEPTH_CNT);
  assign busy      = (state != S_IDLE);
  assign bit_last  = (bit_cnt == BIT_LAST);
  // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
  assign push_ok   = push && (!full || pop);
  assign unused_bits = ^{addr[31:8], wdata[31:8]};

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    frame_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: if (bit_last) state_nxt = S_DATA;
      S_DATA:  if (bit_last && (bit_idx == 3'd7)) state_nxt = S_STOP;
      S_STOP: begin
        if (bit_last) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            frame_end = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Line driver is registered from the current state, so the start bit
  // appears two cycles after the TXD write and every bit lasts CLKS_PER_BIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_line <= 1'b1;
      shift   <= '0;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        S_START: tx_line <= 1'b0;
        S_DATA:  tx_line <= shift[0];
        default: tx_line <= 1'b1;
      endcase
      if (pop) begin
        shift   <= mem[rd_ptr];
        bit_cnt <= '0;
        bit_idx <= '0;
      end else if (state != S_IDLE) begin
        if (bit_last) begin
          bit_cnt <= '0;
          if (state == S_DATA) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end else begin
          bit_cnt <= bit_cnt + BCNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_next(wr_ptr);
      if (pop)     rd_ptr <= ptr_next(rd_ptr);
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_en  <= 1'b0;
      tx_done <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (con_wr) irq_en <= wdata[3];
      if (frame_end)                tx_done <= 1'b1;
      else if (con_wr && wdata[4])  tx_done <= 1'b0;
      if (push && !push_ok)         ovf <= 1'b1;
      else if (con_wr && wdata[5])  ovf <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd && (addr[7:0] == ADDR_CON))
      rdata = {22'b0, cnt, ovf, tx_done, irq_en, empty, full, busy};
  end

  assign UART_TX = tx_line;
  assign irqout  = irq_en & tx_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_periph.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_periph : directed self-checking bench for uart_tx_periph
// Revision 1.0
// ============================================================================
module tb_uart_tx_periph;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        UART_TX;
  logic        irqout;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_bytes [16];
  int         n_bytes = 0;
  logic [31:0] rv;

  always #5 clk = ~clk;

  uart_tx_periph #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .UART_TX(UART_TX), .irqout(irqout)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Expected line level k negedges after the posedge that pushed the first byte.
  function automatic logic exp_tx(input int k);
    int idx, pos;
    if (k < 2) return 1'b1;
    idx = (k - 2) / FRAME;
    pos = ((k - 2) % FRAME) / CPB;
    if (idx >= n_bytes) return 1'b1;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return exp_bytes[idx][pos-1];
  endfunction

  function automatic logic [31:0] con(input int c, input bit ov, input bit done,
                                      input bit en, input bit emp, input bit fl, input bit bsy);
    logic [3:0] c4;
    c4 = c[3:0];
    return {22'b0, c4, ov, done, en, emp, fl, bsy};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    addr = a; rd = 1'b1;
    #1;
    v = rdata;
    rd = 1'b0;
  endtask

  task automatic check_con(input string tag, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(32'h20, v);
    check_val(tag, v, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and register map basics
    do_reset();
    check_val("rst_tx", UART_TX, 1'b1);
    check_val("rst_irq", irqout, 1'b0);
    check_con("rst_con", con(0, 0, 0, 0, 1, 0, 0));
    bus_read(32'h18, rv);
    check_val("rd_txd_zero", rv, 32'h0);
    addr = 32'h20; #1;
    check_val("rd_idle_zero", rdata, 32'h0);

    // Test 1: single frame of 0x55
    exp_bytes[0] = 8'h55; n_bytes = 1;
    bus_write(32'h18, 32'h55);
    tick(1);
    check_con("t1_busy", con(0, 0, 0, 0, 1, 0, 1));
    for (int k = 1; k <= 41; k++) begin
      check_val($sformatf("t1_tx_k%0d", k), UART_TX, exp_tx(k));
      if (k < 41) tick(1);
    end
    check_con("t1_done", con(0, 0, 1, 0, 1, 0, 0));

    // Test 2: interrupt on frame completion, then CPU clear
    bus_write(32'h20, 32'h18);
    check_con("t2_en", con(0, 0, 0, 1, 1, 0, 0));
    check_val("t2_irq_low", irqout, 1'b0);
    exp_bytes[0] = 8'hA3; n_bytes = 1;
    bus_write(32'h18, 32'hA3);
    tick(1);
    for (int k = 1; k <= 41; k++) begin
      check_val($sformatf("t2_tx_k%0d", k), UART_TX, exp_tx(k));
      if (k == 40) check_val("t2_irq_before", irqout, 1'b0);
      if (k < 41) tick(1);
    end
    check_val("t2_irq_rise", irqout, 1'b1);
    bus_write(32'h20, 32'h18);
    check_val("t2_irq_fall", irqout, 1'b0);
    check_con("t2_con", con(0, 0, 0, 1, 1, 0, 0));

    // Test 3: three back-to-back frames
    exp_bytes[0] = 8'h01; exp_bytes[1] = 8'h02; exp_bytes[2] = 8'h03; n_bytes = 3;
    bus_write(32'h18, 32'h01);
    bus_write(32'h18, 32'h02);
    bus_write(32'h18, 32'h03);
    for (int k = 2; k <= 122; k++) begin
      check_val($sformatf("t3_tx_k%0d", k), UART_TX, exp_tx(k));
      if (k == 10)  check_con("t3_cnt2", con(2, 0, 0, 1, 0, 0, 1));
      if (k == 41)  check_con("t3_f2", con(1, 0, 0, 1, 0, 0, 1));
      if (k == 81)  check_con("t3_f3", con(0, 0, 0, 1, 1, 0, 1));
      if (k == 120) check_con("t3_notdone", con(0, 0, 0, 1, 1, 0, 1));
      if (k == 121) begin
        check_con("t3_done", con(0, 0, 1, 1, 1, 0, 0));
        check_val("t3_irq", irqout, 1'b1);
      end
      if (k < 122) tick(1);
    end

    // Test 4: ten writes while idle -> overflow, nine frames
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_bytes[i] = 8'h10 + 8'(i);
      bus_write(32'h18, 32'h10 + 32'(i));
    end
    n_bytes = 9;
    check_con("t4_full_ovf", con(8, 1, 0, 0, 0, 1, 1));
    for (int k = 9; k <= 362; k++) begin
      check_val($sformatf("t4_tx_k%0d", k), UART_TX, exp_tx(k));
      if (k == 321) check_con("t4_last_pop", con(0, 1, 0, 0, 1, 0, 1));
      if (k == 361) begin
        check_con("t4_done", con(0, 1, 1, 0, 1, 0, 0));
        check_val("t4_irq_masked", irqout, 1'b0);
      end
      if (k < 362) tick(1);
    end
    bus_write(32'h20, 32'h30);
    check_con("t4_clear", con(0, 0, 0, 0, 1, 0, 0));

    // Test 5: push into a full FIFO in the cycle STOP pops
    do_reset();
    for (int i = 0; i < 9; i++) bus_write(32'h18, 32'h30 + 32'(i));
    check_con("t5_full", con(8, 0, 0, 0, 0, 1, 1));
    tick(32);
    bus_write(32'h18, 32'h20);
    check_con("t5_accept", con(8, 0, 0, 0, 0, 1, 1));
    check_val("t5_stop", UART_TX, 1'b1);
    tick(1);
    check_val("t5_next_start", UART_TX, 1'b0);

    // Test 6: reset mid-DATA, then reset mid-START
    do_reset();
    bus_write(32'h18, 32'hFF);
    bus_write(32'h18, 32'h00);
    tick(14);
    check_con("t6_pre", con(1, 0, 0, 0, 0, 0, 1));
    reset = 1'b0;
    tick(1);
    check_val("t6_tx", UART_TX, 1'b1);
    check_val("t6_irq", irqout, 1'b0);
    check_con("t6_con", con(0, 0, 0, 0, 1, 0, 0));
    bus_read(32'h30, rv);
    check_val("t6_unmapped", rv, 32'h0);
    reset = 1'b1;
    tick(1);
    bus_write(32'h18, 32'h00);
    tick(3);
    check_val("t6_start_low", UART_TX, 1'b0);
    reset = 1'b0;
    tick(1);
    check_val("t6_abort_tx", UART_TX, 1'b1);
    reset = 1'b1;
    tick(2);
    check_val("t6_idle_tx", UART_TX, 1'b1);
    check_con("t6_idle_con", con(0, 0, 0, 0, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
